// File: rtl/lfsr_mem_checker.sv
// lfsr_mem_checker: memory self-test engine driven by an upstream LFSR.
//
// For each of NUM_OPS operations it captures a pseudo-random word address and
// data word from the LFSR inputs. It writes the word to memory, reads it back
// and compares the result. An operation is an error when the read data
// mismatches, or when no read data arrives within TIMEOUT cycles after the
// read is granted. All outputs are registered.
//
// Ports
//   clk            clock, rising edge
//   rstn           synchronous active-low reset
//   start          run request, honoured only while idle
//   lfsr_data      write data candidate, new value every cycle
//   lfsr_addr      word address candidate, new value every cycle
//   mem_req        request valid
//   mem_we         1 = write, 0 = read
//   mem_addr       request word address
//   mem_wdata      write data
//   mem_gnt        request accepted when mem_req && mem_gnt at a rising edge
//   mem_rvalid     read data valid (single-cycle pulse)
//   mem_rdata      read data
//   busy           run in progress (low again in the done cycle)
//   done           one-cycle pulse at end of run
//   fail           sticky error flag for the current run
//   err_count      saturating error count for the current run
//   first_err_addr address of the first failing operation of the current run
module lfsr_mem_checker #(
  parameter int unsigned NUM_OPS = 256,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic [31:0] lfsr_data,
  input  logic [9:0]  lfsr_addr,
  output logic        mem_req,
  output logic        mem_we,
  output logic [9:0]  mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        done,
  output logic        fail,
  output logic [15:0] err_count,
  output logic [9:0]  first_err_addr
);

  typedef enum logic [2:0] {
    StIdle,
    StWr,
    StRd,
    StRwait,
    StDone
  } state_e;

  localparam logic [15:0] NumOpsW  = 16'(NUM_OPS);
  localparam logic [7:0]  TimeoutW = 8'(TIMEOUT);

  state_e      state_q;
  logic [31:0] wdata_q;
  logic [9:0]  addr_q;
  logic [15:0] op_cnt_q;
  logic [7:0]  tmo_q;
  logic        mem_req_q;
  logic        mem_we_q;
  logic        busy_q;
  logic        done_q;
  logic        fail_q;
  logic [15:0] err_cnt_q;
  logic [9:0]  first_err_q;

  logic [7:0]  tmo_inc;
  logic        tmo_hit;
  logic        op_end;
  logic        op_err;
  logic [15:0] op_cnt_inc;
  logic        last_op;

  // Read-wait outcome for the current cycle. Read data arriving in the same
  // cycle the timeout would expire still counts as a valid response.
  always_comb begin
    tmo_inc    = tmo_q + 8'd1;
    tmo_hit    = (tmo_inc == TimeoutW);
    op_end     = (state_q == StRwait) && (mem_rvalid || tmo_hit);
    op_err     = op_end && (mem_rvalid ? (mem_rdata != wdata_q) : 1'b1);
    op_cnt_inc = op_cnt_q + 16'd1;
    last_op    = (op_cnt_inc == NumOpsW);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= StIdle;
      wdata_q     <= '0;
      addr_q      <= '0;
      op_cnt_q    <= '0;
      tmo_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      err_cnt_q   <= '0;
      first_err_q <= '0;
    end else begin
      done_q <= 1'b0;

      if (op_err) begin
        if (err_cnt_q != 16'hFFFF) begin
          err_cnt_q <= err_cnt_q + 16'd1;
        end
        if (!fail_q) begin
          fail_q      <= 1'b1;
          first_err_q <= addr_q;
        end
      end

      unique case (state_q)
        StIdle: begin
          if (start) begin
            wdata_q     <= lfsr_data;
            addr_q      <= lfsr_addr;
            op_cnt_q    <= '0;
            err_cnt_q   <= '0;
            fail_q      <= 1'b0;
            first_err_q <= '0;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= StWr;
          end
        end

        // Address and data are held in addr_q/wdata_q, so they stay stable
        // for as long as the grant is withheld.
        StWr: begin
          if (mem_gnt) begin
            mem_we_q <= 1'b0;
            state_q  <= StRd;
          end
        end

        StRd: begin
          if (mem_gnt) begin
            mem_req_q <= 1'b0;
            tmo_q     <= '0;
            state_q   <= StRwait;
          end
        end

        StRwait: begin
          if (op_end) begin
            op_cnt_q <= op_cnt_inc;
            if (last_op) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= StDone;
            end else begin
              wdata_q   <= lfsr_data;
              addr_q    <= lfsr_addr;
              mem_req_q <= 1'b1;
              mem_we_q  <= 1'b1;
              state_q   <= StWr;
            end
          end else begin
            tmo_q <= tmo_inc;
          end
        end

        StDone: begin
          state_q <= StIdle;
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign mem_req        = mem_req_q;
  assign mem_we         = mem_we_q;
  assign mem_addr       = addr_q;
  assign mem_wdata      = wdata_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign fail           = fail_q;
  assign err_count      = err_cnt_q;
  assign first_err_addr = first_err_q;

endmodule

// File: tb/tb_lfsr_mem_checker.sv
// Bench for lfsr_mem_checker. dut_a (NUM_OPS=4) runs against a behavioural
// memory. dut_b (NUM_OPS=3, TIMEOUT=8) sees a memory that never returns data.
// The LFSR inputs are a known function of the cycle number, so the bench can
// predict every captured address and data word on its own.
module tb_lfsr_mem_checker;

  logic        clk;
  logic        rstn;
  logic        start;
  logic        start_b;
  logic [31:0] lfsr_data;
  logic [9:0]  lfsr_addr;

  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        busy, done, fail;
  logic [15:0] err_count;
  logic [9:0]  first_err_addr;

  logic        mem_req_b, mem_we_b, busy_b, done_b, fail_b;
  logic        mem_gnt_b, mem_rvalid_b;
  logic [9:0]  mem_addr_b, first_err_addr_b;
  logic [31:0] mem_wdata_b, mem_rdata_b;
  logic [15:0] err_count_b;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  typedef struct packed {
    logic [9:0]  addr;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    logic [3:0]  flip_ops;
    logic [31:0] flip_mask;
    int          exp_err;
    logic        exp_fail;
    int          first_op;
  } vec_t;
  vec_t vecs[6];

  // Memory model controls
  logic [3:0]  flip_ops  = 4'b0000;
  logic [31:0] flip_mask = 32'h0;
  int          rd_op     = 0;
  int          rv_lat    = 1;
  logic        sb_on     = 1'b0;
  logic [9:0]  exp_rd_addr = '0;

  lfsr_mem_checker #(.NUM_OPS(4), .TIMEOUT(8)) dut_a (
    .clk           (clk),
    .rstn          (rstn),
    .start         (start),
    .lfsr_data     (lfsr_data),
    .lfsr_addr     (lfsr_addr),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_gnt       (mem_gnt),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata),
    .busy          (busy),
    .done          (done),
    .fail          (fail),
    .err_count     (err_count),
    .first_err_addr(first_err_addr)
  );

  lfsr_mem_checker #(.NUM_OPS(3), .TIMEOUT(8)) dut_b (
    .clk           (clk),
    .rstn          (rstn),
    .start         (start_b),
    .lfsr_data     (lfsr_data),
    .lfsr_addr     (lfsr_addr),
    .mem_req       (mem_req_b),
    .mem_we        (mem_we_b),
    .mem_addr      (mem_addr_b),
    .mem_wdata     (mem_wdata_b),
    .mem_gnt       (mem_gnt_b),
    .mem_rvalid    (mem_rvalid_b),
    .mem_rdata     (mem_rdata_b),
    .busy          (busy_b),
    .done          (done_b),
    .fail          (fail_b),
    .err_count     (err_count_b),
    .first_err_addr(first_err_addr_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] gen_data(input int n);
    return (32'(n) * 32'h9E37_79B9) ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic [9:0] gen_addr(input int n);
    logic [31:0] x;
    x = (32'(n) * 32'h0001_9A4D) + 32'h0000_0133;
    return x[17:8];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // LFSR stand-in: value sampled at a rising edge is a function of cyc.
  initial begin
    lfsr_data = gen_data(0);
    lfsr_addr = gen_addr(0);
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      lfsr_data = gen_data(cyc);
      lfsr_addr = gen_addr(cyc);
    end
  end

  // Memory model for dut_a, evaluated just after each falling edge: a request
  // seen here with grant high is accepted at the next rising edge.
  logic [31:0] mem [1024];
  int          rd_cnt  = 0;
  logic [9:0]  rd_addr = '0;
  initial begin
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    forever begin
      @(negedge clk);
      #1;
      mem_rvalid = 1'b0;
      if (rd_cnt != 0) begin
        rd_cnt--;
        if (rd_cnt == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = mem[rd_addr];
          if (rd_op < 4 && flip_ops[rd_op]) mem_rdata = mem_rdata ^ flip_mask;
          rd_op++;
        end
      end
      if (rstn && mem_req && mem_gnt) begin
        if (mem_we) begin
          mem[mem_addr] = mem_wdata;
          if (sb_on) begin
            chk("sb_wr_pending", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
              exp_t e;
              e = exp_q.pop_front();
              chk("sb_wr_addr", 32'(mem_addr), 32'(e.addr));
              chk("sb_wr_data", mem_wdata, e.data);
              exp_rd_addr = e.addr;
            end
          end
        end else begin
          rd_addr = mem_addr;
          rd_cnt  = rv_lat;
          if (sb_on) chk("sb_rd_addr", 32'(mem_addr), 32'(exp_rd_addr));
        end
      end
    end
  end

  // Ideal-memory run of dut_a with optional read-data corruption.
  task automatic run_vec(input int idx, input vec_t v);
    int         c0;
    int         lat;
    logic [9:0] exp_first;
    exp_t       e;
    @(negedge clk);
    flip_ops  = v.flip_ops;
    flip_mask = v.flip_mask;
    rd_op     = 0;
    exp_q.delete();
    c0 = cyc;
    for (int i = 0; i < 4; i++) begin
      e.addr = gen_addr(c0 + 3 * i);
      e.data = gen_data(c0 + 3 * i);
      exp_q.push_back(e);
    end
    exp_first = (v.first_op >= 0) ? gen_addr(c0 + 3 * v.first_op) : 10'd0;
    sb_on = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = 0;
    chk($sformatf("v%0d_first_req", idx), 32'(mem_req), 32'd1);
    chk($sformatf("v%0d_busy", idx), 32'(busy), 32'd1);
    while (done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk($sformatf("v%0d_done_lat", idx), 32'(lat), 32'd12);
    chk($sformatf("v%0d_busy_in_done", idx), 32'(busy), 32'd0);
    chk($sformatf("v%0d_err_count", idx), 32'(err_count), 32'(v.exp_err));
    chk($sformatf("v%0d_fail", idx), 32'(fail), 32'(v.exp_fail));
    chk($sformatf("v%0d_first_err", idx), 32'(first_err_addr), 32'(exp_first));
    @(negedge clk);
    chk($sformatf("v%0d_done_pulse", idx), 32'(done), 32'd0);
    chk($sformatf("v%0d_sb_empty", idx), 32'(exp_q.size()), 32'd0);
    sb_on = 1'b0;
  endtask

  initial begin
    int         c0;
    int         lat;
    int         n_done;
    int         done_lat;
    logic       any_req;
    logic       any_busy;
    exp_t       e;

    vecs[0] = '{flip_ops: 4'b0000, flip_mask: 32'h0000_0000, exp_err: 0, exp_fail: 1'b0,
                first_op: -1};
    vecs[1] = '{flip_ops: 4'b0100, flip_mask: 32'h0000_0001, exp_err: 1, exp_fail: 1'b1,
                first_op: 2};
    vecs[2] = '{flip_ops: 4'b0001, flip_mask: 32'h8000_0000, exp_err: 1, exp_fail: 1'b1,
                first_op: 0};
    vecs[3] = '{flip_ops: 4'b1010, flip_mask: 32'h0000_0F00, exp_err: 2, exp_fail: 1'b1,
                first_op: 1};
    vecs[4] = '{flip_ops: 4'b1111, flip_mask: 32'hFFFF_FFFF, exp_err: 4, exp_fail: 1'b1,
                first_op: 0};
    vecs[5] = '{flip_ops: 4'b0000, flip_mask: 32'h0000_0000, exp_err: 0, exp_fail: 1'b0,
                first_op: -1};

    rstn         = 1'b0;
    start        = 1'b0;
    start_b      = 1'b0;
    mem_gnt      = 1'b1;
    mem_gnt_b    = 1'b1;
    mem_rvalid_b = 1'b0;
    mem_rdata_b  = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_fail", 32'(fail), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    chk("rst_first_err", 32'(first_err_addr), 32'd0);
    chk("rst_b_busy", 32'(busy_b), 32'd0);
    rstn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    // Grant withheld in WR: request must hold steady, then RD follows grant.
    @(negedge clk);
    flip_ops = 4'b0000;
    rd_op    = 0;
    exp_q.delete();
    c0 = cyc;
    e.addr = gen_addr(c0);      e.data = gen_data(c0);      exp_q.push_back(e);
    e.addr = gen_addr(c0 + 8);  e.data = gen_data(c0 + 8);  exp_q.push_back(e);
    e.addr = gen_addr(c0 + 11); e.data = gen_data(c0 + 11); exp_q.push_back(e);
    e.addr = gen_addr(c0 + 14); e.data = gen_data(c0 + 14); exp_q.push_back(e);
    mem_gnt = 1'b0;
    sb_on   = 1'b1;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("stall%0d_req", k), 32'(mem_req), 32'd1);
      chk($sformatf("stall%0d_we", k), 32'(mem_we), 32'd1);
      chk($sformatf("stall%0d_addr", k), 32'(mem_addr), 32'(gen_addr(c0)));
      chk($sformatf("stall%0d_wdata", k), mem_wdata, gen_data(c0));
      if (k < 5) @(negedge clk);
    end
    mem_gnt = 1'b1;
    @(negedge clk);
    chk("stall_rd_req", 32'(mem_req), 32'd1);
    chk("stall_rd_we", 32'(mem_we), 32'd0);
    chk("stall_rd_addr", 32'(mem_addr), 32'(gen_addr(c0)));
    lat = 6;
    while (done !== 1'b1 && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    chk("stall_done_lat", 32'(lat), 32'd17);
    chk("stall_err_count", 32'(err_count), 32'd0);
    @(negedge clk);
    chk("stall_sb_empty", 32'(exp_q.size()), 32'd0);
    sb_on = 1'b0;

    // Read timeout on dut_b: each op ends 8 cycles after its read grant.
    @(negedge clk);
    c0      = cyc;
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    lat     = 0;
    repeat (9) begin
      @(negedge clk);
      lat++;
    end
    chk("tmo_rwait_req", 32'(mem_req_b), 32'd0);
    chk("tmo_rwait_err", 32'(err_count_b), 32'd0);
    @(negedge clk);
    lat++;
    chk("tmo_next_req", 32'(mem_req_b), 32'd1);
    chk("tmo_next_we", 32'(mem_we_b), 32'd1);
    chk("tmo_next_addr", 32'(mem_addr_b), 32'(gen_addr(c0 + 10)));
    chk("tmo_err_after_op0", 32'(err_count_b), 32'd1);
    while (done_b !== 1'b1 && lat < 80) begin
      @(negedge clk);
      lat++;
    end
    chk("tmo_done_lat", 32'(lat), 32'd30);
    chk("tmo_err_count", 32'(err_count_b), 32'd3);
    chk("tmo_fail", 32'(fail_b), 32'd1);
    chk("tmo_first_err", 32'(first_err_addr_b), 32'(gen_addr(c0)));

    // Reset in RWAIT with corrupt read data arriving the cycle after reset.
    @(negedge clk);
    flip_ops  = 4'b0001;
    flip_mask = 32'h0000_0001;
    rd_op     = 0;
    rv_lat    = 2;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn     = 1'b1;
    any_req  = 1'b0;
    any_busy = 1'b0;
    n_done   = 0;
    for (int k = 0; k < 8; k++) begin
      any_req  = any_req | mem_req;
      any_busy = any_busy | busy;
      if (done === 1'b1) n_done++;
      @(negedge clk);
    end
    chk("rstmid_req", 32'(any_req), 32'd0);
    chk("rstmid_busy", 32'(any_busy), 32'd0);
    chk("rstmid_done", 32'(n_done), 32'd0);
    chk("rstmid_err", 32'(err_count), 32'd0);
    chk("rstmid_fail", 32'(fail), 32'd0);
    rv_lat   = 1;
    flip_ops = 4'b0000;

    // start pulses while busy and in the done cycle are ignored.
    @(negedge clk);
    rd_op = 0;
    start = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    n_done   = 0;
    done_lat = -1;
    for (int k = 0; k < 30; k++) begin
      if (done === 1'b1) begin
        n_done++;
        done_lat = k;
      end
      start = (k == 4 || k == 7 || k == 12);
      @(negedge clk);
    end
    start = 1'b0;
    chk("restart_done_count", 32'(n_done), 32'd1);
    chk("restart_done_lat", 32'(done_lat), 32'd12);
    chk("restart_busy_end", 32'(busy), 32'd0);
    chk("restart_err", 32'(err_count), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
